cla_nibble_seq_adder: RTL and testbench

Sequencing controller that performs a WIDTH-bit addition by time-multiplexing one shared 4-bit CLA adder (FA_4bits), one nibble per cycle, LSB nibble first. A register carries the carry from one nibble to the next. The block sits beside FA_4bits in the adder hierarchy. It drives the adder's a/b/cin and samples its sum/carry.

---
 rtl/cla_nibble_seq_adder_pkg.sv | 19 +
 rtl/FA_4bits.sv | 28 ++
 rtl/cla_seq_add_top.sv | 45 ++++
 rtl/cla_nibble_seq_adder.sv | 118 +++++++++++
 tb/tb_cla_nibble_seq_adder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_nibble_seq_adder_pkg.sv
// Shared definitions for the nibble-serial adder: controller state encoding
// and a constant-evaluable ceil(log2) helper.
package cla_nibble_seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/FA_4bits.sv
// Pure combinational 4-bit carry-lookahead adder shared by the nibble sequencer.
module FA_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p/cin, no ripple chain.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum   = p ^ c[3:0];
    assign carry = c[4];

endmodule

// File: rtl/cla_seq_add_top.sv
// Sequencer paired with its shared 4-bit CLA, for use as a standalone adder.
module cla_seq_add_top #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [3:0] fa_a, fa_b, fa_sum;
    logic       fa_cin, fa_carry;

    cla_nibble_seq_adder #(.WIDTH(WIDTH)) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_cin   (fa_cin),
        .fa_sum   (fa_sum),
        .fa_carry (fa_carry)
    );

    FA_4bits u_fa (
        .a     (fa_a),
        .b     (fa_b),
        .cin   (fa_cin),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

endmodule

// File: rtl/cla_nibble_seq_adder.sv
// Sequencer that adds two WIDTH-bit operands one nibble per cycle through an
// external shared 4-bit adder, carrying between nibbles in carry_reg.
module cla_nibble_seq_adder
    import cla_nibble_seq_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       fa_a,
    output logic [3:0]       fa_b,
    output logic             fa_cin,
    input  logic [3:0]       fa_sum,
    input  logic             fa_carry
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (clog2(NIB) > 1) ? clog2(NIB) : 1;

    state_t           state_reg, state_next;
    logic [IDXW-1:0]  idx_reg;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_merge;
    logic             carry_reg, cout_reg;
    logic             accept, last;

    assign accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign last   = (state_reg == ST_RUN) && (idx_reg == IDXW'(NIB - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

    // Adder inputs come only from registers, so start/a/b never reach fa_*.
    always_comb begin
        fa_a   = '0;
        fa_b   = '0;
        fa_cin = 1'b0;
        if (state_reg == ST_RUN) begin
            fa_cin = carry_reg;
            for (int i = 0; i < NIB; i++) begin
                if (idx_reg == IDXW'(i)) begin
                    fa_a = a_reg[4*i +: 4];
                    fa_b = b_reg[4*i +: 4];
                end
            end
        end
    end

    // Per-nibble accumulator; the nibble being computed is bypassed into
    // sum_merge so the final edge can load the complete result directly.
    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_nib
            logic [3:0] acc_reg;
            logic       hit;

            assign hit = (state_reg == ST_RUN) && (idx_reg == IDXW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (hit) begin
                    acc_reg <= fa_sum;
                end
            end

            assign sum_merge[4*gi +: 4] = hit ? fa_sum : acc_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                idx_reg   <= '0;
            end else if (state_reg == ST_RUN) begin
                carry_reg <= fa_carry;
                if (last) begin
                    sum_reg  <= sum_merge;
                    cout_reg <= fa_carry;
                    idx_reg  <= '0;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Directed and random checks of the nibble-serial adder at WIDTH=16 and WIDTH=4.
module tb_cla_nibble_seq_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;
    logic [3:0]  fa_a16, fa_b16, fa_sum16;
    logic        fa_cin16, fa_carry16;

    logic        start4, cin4, busy4, done4, cout4;
    logic [3:0]  a4, b4, sum4;

    logic [16:0] sb16[$];
    logic [4:0]  sb4[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    cla_nibble_seq_adder #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start16),
        .a        (a16),
        .b        (b16),
        .cin      (cin16),
        .busy     (busy16),
        .done     (done16),
        .sum      (sum16),
        .cout     (cout16),
        .fa_a     (fa_a16),
        .fa_b     (fa_b16),
        .fa_cin   (fa_cin16),
        .fa_sum   (fa_sum16),
        .fa_carry (fa_carry16)
    );

    FA_4bits u_fa16 (
        .a     (fa_a16),
        .b     (fa_b16),
        .cin   (fa_cin16),
        .sum   (fa_sum16),
        .carry (fa_carry16)
    );

    cla_seq_add_top #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic drive16(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input bit push);
        start16 = 1'b1;
        a16 = ta;
        b16 = tb;
        cin16 = tc;
        if (push) sb16.push_back({1'b0, ta} + {1'b0, tb} + {16'd0, tc});
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait16(input string tag, input int exp_busy, output logic [3:0] cins);
        int          nbusy = 0;
        bit          got = 0;
        logic [16:0] exp;
        cins = '0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (done16) begin
                got = 1;
            end else begin
                if (busy16) begin
                    if (nbusy < 4) cins[nbusy] = fa_cin16;
                    nbusy++;
                end
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            if (exp_busy >= 0) chk({tag, "_busy_cycles"}, nbusy, exp_busy);
            if (sb16.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
            end else begin
                exp = sb16.pop_front();
                chk({tag, "_sum"}, 32'(sum16), 32'(exp[15:0]));
                chk({tag, "_cout"}, 32'(cout16), 32'(exp[16]));
            end
            $display("op16 %s sum=%h cout=%0d busy_cycles=%0d", tag, sum16, cout16, nbusy);
        end
    endtask

    task automatic drive4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        start4 = 1'b1;
        a4 = ta;
        b4 = tb;
        cin4 = tc;
        sb4.push_back({1'b0, ta} + {1'b0, tb} + {4'd0, tc});
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait4(input string tag, input bit verbose);
        int         nbusy = 0;
        bit         got = 0;
        logic [4:0] exp;
        for (int k = 0; k < 10 && !got; k++) begin
            if (done4) begin
                got = 1;
            end else begin
                if (busy4) nbusy++;
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_busy_cycles"}, nbusy, 1);
            if (sb4.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
            end else begin
                exp = sb4.pop_front();
                chk({tag, "_sum"}, 32'(sum4), 32'(exp[3:0]));
                chk({tag, "_cout"}, 32'(cout4), 32'(exp[4]));
            end
            if (verbose) $display("op4 %s a=%h b=%h cin=%0d sum=%h cout=%0d", tag, a4, b4, cin4, sum4, cout4);
        end
    endtask

    initial begin
        logic [3:0] cins;
        int         extra;

        rst_n = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        start4 = 1'b0;  a4 = '0;  b4 = '0;  cin4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(done16), 32'd0);
        chk("rst_sum", 32'(sum16), 32'd0);
        chk("rst_cout", 32'(cout16), 32'd0);
        chk("rst_fa_a", 32'(fa_a16), 32'd0);
        chk("rst_fa_cin", 32'(fa_cin16), 32'd0);
        chk("rst_sum4", 32'(sum4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add, latency and busy length
        drive16(16'h1234, 16'h4321, 1'b0, 1);
        wait16("t1", 4, cins);
        chk("t1_sum_5555", 32'(sum16), 32'h5555);
        @(negedge clk);
        chk("t1_done_one_cycle", 32'(done16), 32'd0);
        chk("t1_idle_fa_a", 32'(fa_a16), 32'd0);
        chk("t1_idle_fa_b", 32'(fa_b16), 32'd0);

        // Carry ripples through every nibble step
        drive16(16'hFFFF, 16'h0001, 1'b0, 1);
        wait16("t2", 4, cins);
        chk("t2_fa_cin_nib0", 32'(cins[0]), 32'd0);
        chk("t2_fa_cin_nib123", 32'(cins[3:1]), 32'h7);
        @(negedge clk);

        // Back-to-back issue from DONE; previous result held meanwhile
        drive16(16'hFFFF, 16'hFFFF, 1'b1, 1);
        wait16("t3a", 4, cins);
        drive16(16'h0001, 16'h0002, 1'b0, 1);
        chk("t3_b2b_busy", 32'(busy16), 32'd1);
        chk("t3_sum_held", 32'(sum16), 32'hFFFF);
        repeat (2) @(negedge clk);
        chk("t3_sum_held_mid", 32'(sum16), 32'hFFFF);
        chk("t3_cout_held_mid", 32'(cout16), 32'd1);
        wait16("t3b", 2, cins);
        @(negedge clk);

        // start during RUN must be ignored
        drive16(16'h1111, 16'h2222, 1'b0, 1);
        start16 = 1'b1; a16 = 16'hABCD; b16 = 16'h1357; cin16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        wait16("t4", 3, cins);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done16) extra++;
        end
        chk("t4_extra_done", extra, 0);
        chk("t4_sb_empty", sb16.size(), 0);

        // Asynchronous reset at idx=2 discards the operation
        drive16(16'h7777, 16'h1111, 1'b0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy16), 32'd0);
        chk("t5_rst_done", 32'(done16), 32'd0);
        chk("t5_rst_sum", 32'(sum16), 32'd0);
        chk("t5_rst_cout", 32'(cout16), 32'd0);
        chk("t5_rst_fa_a", 32'(fa_a16), 32'd0);
        chk("t5_rst_fa_b", 32'(fa_b16), 32'd0);
        chk("t5_rst_fa_cin", 32'(fa_cin16), 32'd0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done16) extra++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done16) extra++;
        end
        chk("t5_no_done", extra, 0);
        drive16(16'h0F0F, 16'h00F1, 1'b0, 1);
        wait16("t5", 4, cins);
        chk("t5_sum_1000", 32'(sum16), 32'h1000);
        @(negedge clk);

        // Random 16-bit ops, mixing idle gaps and back-to-back issue
        for (int n = 0; n < 40; n++) begin
            drive16(16'($urandom), 16'($urandom), 1'($urandom), 1);
            wait16("r16", 4, cins);
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end

        // WIDTH=4 instance: single-step operation
        drive4(4'h9, 4'h8, 1'b1);
        wait4("w4", 1);
        chk("w4_sum_2", 32'(sum4), 32'h2);
        chk("w4_cout_1", 32'(cout4), 32'd1);
        @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            drive4(4'($urandom), 4'($urandom), 1'($urandom));
            wait4("r4", 0);
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        chk("r4_sb_empty", sb4.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
